// File: rtl/rr_arb_mux_2x1.sv
// rr_arb_mux_2x1
//   Registered, handshaked 2:1 front end. A round-robin arbiter picks one of
//   two producer channels each cycle. The chosen word is captured in a
//   one-entry output register, and the select that produced it goes out on s.
//
// Ports
//   clk, rst_n           : rising-edge clock, async active-low reset
//   d0/d0_valid/d0_ready : channel 0 (ready is combinational)
//   d1/d1_valid/d1_ready : channel 1 (ready is combinational)
//   outp/out_valid       : registered output word and its valid
//   out_ready            : consumer accepts outp this cycle
//   s                    : channel that supplied outp (0 = d0, 1 = d1)
//   cnt0/cnt1            : per-channel saturating transfer counters
module rr_arb_mux_2x1 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic             d0_valid,
    output logic             d0_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic             d1_valid,
    output logic             d1_ready,
    output logic [WIDTH-1:0] outp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nx;
    logic   last;      // channel granted most recently; a tie goes to the other one
    logic   load_en;
    logic   gnt_any;
    logic   gnt_sel;   // 0 = d0, 1 = d1, meaningful only when gnt_any
    logic   xfer;

    assign out_valid = (state == FULL);

    // The slot can take a new word when it is empty or being drained this
    // cycle, so a word can pass straight through with no bubble.
    assign load_en = !out_valid || out_ready;

    // The grant depends only on the valids and the pointer, never on the
    // readies, so no combinational loop can form through the handshake.
    always_comb begin
        gnt_any = d0_valid || d1_valid;
        gnt_sel = 1'b0;
        if (d0_valid && d1_valid) gnt_sel = !last;
        else if (d1_valid)        gnt_sel = 1'b1;
    end

    assign d0_ready = load_en && d0_valid && gnt_any && !gnt_sel;
    assign d1_ready = load_en && d1_valid && gnt_any &&  gnt_sel;
    assign xfer     = d0_ready || d1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (xfer) state_nx = FULL;
            FULL:  if (!xfer && out_ready) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    // Datapath: outp and s change only on a transfer and otherwise keep the
    // last word, even after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outp <= '0;
            s    <= 1'b0;
            last <= 1'b1;
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (xfer) begin
            outp <= d1_ready ? d1 : d0;
            s    <= d1_ready;
            last <= d1_ready;
            if (d0_ready && cnt0 != CNT_MAX) cnt0 <= cnt0 + CNT_ONE;
            if (d1_ready && cnt1 != CNT_MAX) cnt1 <= cnt1 + CNT_ONE;
        end
    end

endmodule
